// File: rtl/wave_sel_pkg.sv
// Purpose: shared mode codes, sizes and wrap helpers for the waveform select control.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package wave_sel_pkg;

  localparam int unsigned NUM_MODES = 6;
  localparam int unsigned SEL_W     = 3;

  typedef enum logic [SEL_W-1:0] {
    MODE_SINE     = 3'd0,
    MODE_SQUARE   = 3'd1,
    MODE_TRIANGLE = 3'd2,
    MODE_SAW      = 3'd3,
    MODE_NOISE    = 3'd4,
    MODE_DC       = 3'd5
  } mode_e;

  localparam logic [SEL_W-1:0] LAST_MODE = SEL_W'(NUM_MODES - 1);

  // Step forward around the ring of legal modes.
  function automatic logic [SEL_W-1:0] next_mode(input logic [SEL_W-1:0] cur);
    return (cur == LAST_MODE) ? '0 : cur + 1'b1;
  endfunction

  // Step backward around the ring of legal modes.
  function automatic logic [SEL_W-1:0] prev_mode(input logic [SEL_W-1:0] cur);
    return (cur == '0) ? LAST_MODE : cur - 1'b1;
  endfunction

endpackage

// File: rtl/wave_sel_ctrl_if.sv
// Purpose: bundles the button/switch inputs and select/status outputs of wave_sel_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running levels or single-cycle pulses.
// Ports: master drives btn_next/btn_prev/sw_load/sw_mode and observes sel/sel_onehot/sel_changed;
//        slave is the controller side.
interface wave_sel_ctrl_if;
  import wave_sel_pkg::*;

  logic                 btn_next;
  logic                 btn_prev;
  logic                 sw_load;
  logic [SEL_W-1:0]     sw_mode;
  logic [SEL_W-1:0]     sel;
  logic [NUM_MODES-1:0] sel_onehot;
  logic                 sel_changed;

  modport master (
    output btn_next, btn_prev, sw_load, sw_mode,
    input  sel, sel_onehot, sel_changed
  );

  modport slave (
    input  btn_next, btn_prev, sw_load, sw_mode,
    output sel, sel_onehot, sel_changed
  );

endinterface

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchronizer, stability-count debouncer and rising-edge detector for one button.
// Latency: raw level stable from cycle T appears on btn_level (and btn_press) at T+2+DEBOUNCE_CYCLES.
// Backpressure: none; btn_press is a one-cycle pulse that is not held.
// Ports: clk, rst_n (sync active-low), btn_raw (async), btn_level (debounced), btn_press (rise pulse).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      deb_d1 <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= btn_raw;
      sync2  <= sync1;
      deb_d1 <= deb;
      // Any cycle that agrees with the current debounced level restarts the count,
      // so a bounce anywhere in the window discards progress.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign btn_level = deb;
  assign btn_press = deb & ~deb_d1;

endmodule

// File: rtl/wave_sel_ctrl.sv
// Purpose: debounced next/prev stepping and preset load of the 6-way waveform mux select.
// Latency: button stable from cycle T -> sel/sel_changed at T+3+DEBOUNCE_CYCLES; sw_load -> 1 cycle.
// Backpressure: none; presses coinciding with a load or with each other are dropped.
// Ports: clk, rst_n (sync active-low), bus (slave: btn_next, btn_prev, sw_load, sw_mode in;
//        sel, sel_onehot, sel_changed out).
module wave_sel_ctrl
  import wave_sel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic           clk,
  input  logic           rst_n,
  wave_sel_ctrl_if.slave bus
);

  localparam logic [NUM_MODES-1:0] ONEHOT0 = NUM_MODES'(1);

  logic                 press_next;
  logic                 press_prev;
  logic                 lvl_next;
  logic                 lvl_prev;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     sel_nxt;
  logic [NUM_MODES-1:0] onehot_q;
  logic                 changed_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (bus.btn_next),
    .btn_level (lvl_next),
    .btn_press (press_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (bus.btn_prev),
    .btn_level (lvl_prev),
    .btn_press (press_prev)
  );

  // Debounced levels are not needed by the select logic; only the press pulses are.
  logic unused_levels;
  assign unused_levels = &{1'b0, lvl_next, lvl_prev};

  // sel is the state register of a ring of NUM_MODES states.
  always_comb begin
    sel_nxt = sel_q;
    if (sel_q > LAST_MODE) begin
      sel_nxt = MODE_SINE;              // unreachable code: recover to a legal mode
    end else if (bus.sw_load) begin
      if (bus.sw_mode <= LAST_MODE) begin
        sel_nxt = bus.sw_mode;          // illegal presets leave sel untouched
      end
    end else if (press_next && !press_prev) begin
      sel_nxt = next_mode(sel_q);
    end else if (press_prev && !press_next) begin
      sel_nxt = prev_mode(sel_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q     <= MODE_SINE;
      onehot_q  <= ONEHOT0;
      changed_q <= 1'b0;
    end else begin
      sel_q     <= sel_nxt;
      onehot_q  <= ONEHOT0 << sel_nxt;
      changed_q <= (sel_nxt != sel_q);
    end
  end

  assign bus.sel         = sel_q;
  assign bus.sel_onehot  = onehot_q;
  assign bus.sel_changed = changed_q;

endmodule

// File: tb/tb_wave_sel_ctrl.sv
module tb_wave_sel_ctrl;
  import wave_sel_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_sel_ctrl_if bus();

  wave_sel_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Edge counter: after the Nth posedge, cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SEL_W-1:0] sel;
    int               at;
  } exp_t;

  exp_t expq[$];
  int   asserts = 0;
  int   fails   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every sel_changed pulse must match the oldest expected step, value and cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expq.size() > 0 && expq[0].at < cyc) begin
        asserts++;
        fails++;
        $display("FAIL missing_step: no sel_changed by cycle %0d, expected sel=%0d", expq[0].at, expq[0].sel);
        void'(expq.pop_front());
      end
      if (bus.sel_changed) begin
        if (expq.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL unexpected_step: sel_changed with sel=%0d at cycle %0d, expected none", bus.sel, cyc);
        end else begin
          exp_t e;
          logic [NUM_MODES-1:0] oh;
          e  = expq.pop_front();
          oh = NUM_MODES'(1) << e.sel;
          check("step_sel", 32'(bus.sel), 32'(e.sel));
          check("step_onehot", 32'(bus.sel_onehot), 32'(oh));
          check("step_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_step(input logic [SEL_W-1:0] s, input int delay);
    exp_t e;
    e.sel = s;
    e.at  = cyc + delay;
    expq.push_back(e);
  endtask

  // Clean press: 10 cycles high, 10 low. A debounced step lands 7 edges after the rise.
  task automatic press(input bit nxt, input bit prv, input logic [SEL_W-1:0] exp_s, input bit moves);
    bus.btn_next = nxt;
    bus.btn_prev = prv;
    if (moves) expect_step(exp_s, 7);
    tick(10);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    tick(10);
  endtask

  logic [SEL_W-1:0] wrap_seq [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b0;
    bus.sw_load  = 1'b0;
    bus.sw_mode  = '0;

    // 1: reset with next held; one step after release.
    repeat (3) begin
      @(negedge clk);
      check("rst_sel", 32'(bus.sel), 32'd0);
      check("rst_onehot", 32'(bus.sel_onehot), 32'b000001);
      check("rst_changed", 32'(bus.sel_changed), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_step(3'd1, 7);
    tick(12);
    bus.btn_next = 1'b0;
    tick(10);

    // 2: six forward presses with wrap, then one backward.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0, wrap_seq[i], 1'b1);
    press(1'b0, 1'b1, 3'd5, 1'b1);

    // 3: bouncing next button, then a solid hold: 5 -> 0.
    for (int i = 0; i < 2; i++) begin
      bus.btn_next = 1'b1;
      tick(2);
      bus.btn_next = 1'b0;
      tick(2);
    end
    bus.btn_next = 1'b1;
    expect_step(3'd0, 7);
    tick(10);
    bus.btn_next = 1'b0;
    tick(10);

    // 4: load 3, then both buttons together do nothing.
    bus.sw_mode = 3'd3;
    bus.sw_load = 1'b1;
    expect_step(3'd3, 1);
    tick(1);
    bus.sw_load = 1'b0;
    tick(2);
    press(1'b1, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    check("simul_hold", 32'(bus.sel), 32'd3);
    tick(1);

    // 5: held load pulses once; illegal preset ignored; load masks a press.
    bus.sw_mode = 3'd4;
    bus.sw_load = 1'b1;
    expect_step(3'd4, 1);
    tick(5);
    bus.sw_load = 1'b0;
    tick(2);
    bus.sw_mode = 3'd7;
    bus.sw_load = 1'b1;
    tick(3);
    bus.sw_load = 1'b0;
    @(negedge clk);
    check("illegal_preset", 32'(bus.sel), 32'd4);
    tick(1);
    bus.sw_mode  = 3'd4;
    bus.btn_next = 1'b1;
    tick(6);
    bus.sw_load = 1'b1;   // covers the edge where press_next fires
    tick(1);
    bus.sw_load = 1'b0;
    tick(4);
    bus.btn_next = 1'b0;
    tick(10);
    @(negedge clk);
    check("load_drops_press", 32'(bus.sel), 32'd4);
    tick(1);

    // 6: reset in the middle of a prev debounce.
    bus.btn_prev = 1'b1;
    tick(3);
    rst_n        = 1'b0;
    bus.btn_prev = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(bus.sel), 32'd0);
    check("midrst_changed", 32'(bus.sel_changed), 32'd0);
    tick(20);
    @(negedge clk);
    check("midrst_hold", 32'(bus.sel), 32'd0);

    check("pending_steps", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
